mult_operand_feeder: RTL
========================

MULT_OPERAND_FEEDER -- requirements
Module: mult_operand_feeder

Interface
REQ-001 Parameter N, default 4, number of element pairs per run (N >= 2, power of 2).
REQ-002 Parameter W, default 32, IEEE-754 single word width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 load_we  in  1  operand write strobe.
REQ-006 load_sel  in  1  0 selects bank A, 1 selects bank B.
REQ-007 load_idx  in  log2(N)  element index for the write.
REQ-008 load_data  in  W  operand value.
REQ-009 start  in  1  one-cycle request to run N multiplications.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle pulse after the Nth product is captured.
REQ-012 mult_a, mult_b  out  W each  operands driven to the multiplier.
REQ-013 mult_a_stb, mult_b_stb  out  1 each  operand valid strobes.
REQ-014 mult_a_ack, mult_b_ack  in  1 each  multiplier operand acknowledges.
REQ-015 mult_z  in  W  product from the multiplier.
REQ-016 mult_z_stb  in  1  product valid.
REQ-017 mult_z_ack  out  1  product acknowledge.
REQ-018 rd_idx  in  log2(N)  product buffer read index.
REQ-019 rd_data  out  W  product buffer entry; combinational read.

Function
REQ-020 Handshake rule: a word transfers on a rising edge where its stb and ack are both high; the sender drops stb on that edge.
REQ-021 States: IDLE, SEND, WAIT_Z, NEXT, DONE.
REQ-022 IDLE: load_we writes bank[load_sel][load_idx]. start moves to SEND with index i=0.
REQ-023 SEND: mult_a=A[i] and mult_b=B[i]; each stb is high until its own transfer. A and B may transfer on different edges. When both have transferred, go to WAIT_Z.
REQ-024 WAIT_Z: mult_z_ack is high. On the edge where mult_z_stb&&mult_z_ack, write P[i]=mult_z, drop mult_z_ack, go to NEXT.
REQ-025 NEXT: if i==N-1 go to DONE, else i<=i+1 and go to SEND. This costs one cycle.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 start while busy is ignored; load_we while busy is ignored.
REQ-028 If load_we and start occur in the same IDLE cycle, the write commits and the run uses the updated value.
REQ-029 No timeout: the block waits indefinitely for ack or mult_z_stb.
REQ-030 mult_z_stb outside WAIT_Z is not acknowledged and not captured.
REQ-031 The A and B operand banks are not modified by a run. A new start reuses them.
REQ-032 rd_data is valid at any time. It reflects the last captured value for each index.

Reset
REQ-033 While rst=0, the following are held 0 immediately, independent of clk: state=IDLE, i=0, busy, done, all stb outputs, and mult_z_ack.
REQ-034 Reset clears banks A, B and P to 0x00000000.
REQ-035 Reset mid-run aborts the run; no done pulse is produced afterwards.

Structure
REQ-036 Shared package fp_mm_pkg holds FP_W=32, the default N, and the feeder state encoding.
REQ-037 One sub-module, feeder_regfile (N x W, one write port, one combinational read port, async clear), is instantiated for A, B and P.

Verification
REQ-038 Reset: assert rst=0 mid-cycle -> all outputs 0 before the next edge; rd_data=0 for every index.
REQ-039 Full run: A={0xBFD3E426,0x3F800000,0x40000000,0xC0400000}, B={0x410A8312,0x40000000,0x40400000,0x3F800000}; start with real multiplier -> done once; P[1]=0x40000000, P[2]=0x40C00000, P[3]=0xC0400000; P[0] equals the multiplier's result for pair 0.
REQ-040 Staggered acks: mult_a_ack at cycle 2 and mult_b_ack at cycle 5 of SEND -> a_stb drops after cycle 2, b_stb after cycle 5; exactly one transfer each; WAIT_Z entered after cycle 5.
REQ-041 Back-pressure: mult_z_stb delayed 20 cycles -> mult_z_ack held high throughout, capture on the first stb edge, busy stays high.
REQ-042 Ignored commands: start and load_we(A[0]=0xFFFFFFFF) pulsed during WAIT_Z -> A[0] unchanged, exactly N captures, a single done.
REQ-043 Abort: rst=0 during WAIT_Z of i=2, then release and start again -> stb outputs drop immediately; banks read 0; the new run completes with products of zero operands (0x00000000).

Source files
------------

// File: rtl/fp_mm_pkg.sv
// Shared definitions for the FP multiply operand feeder: word width,
// default run length and the feeder state encoding.
package fp_mm_pkg;

    localparam int FP_W   = 32;
    localparam int FEED_N = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_WAIT_Z = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4
    } feed_state_t;

endpackage

// File: rtl/feeder_regfile.sv
// N x W register file: one synchronous write port, one combinational read
// port, asynchronously cleared to zero.
module feeder_regfile #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic [$clog2(N)-1:0] raddr,
    output logic [W-1:0]         rdata
);

    logic [W-1:0] mem_r [N];

    // Storage array: async clear, single write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                mem_r[k] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mult_operand_feeder.sv
// Streams N operand pairs from banks A/B into a handshaked multiplier and
// stores each product into bank P, pulsing done after the last capture.
module mult_operand_feeder
    import fp_mm_pkg::*;
#(
    parameter int N = FEED_N,
    parameter int W = FP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_we,
    input  logic                 load_sel,
    input  logic [$clog2(N)-1:0] load_idx,
    input  logic [W-1:0]         load_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         mult_a,
    output logic [W-1:0]         mult_b,
    output logic                 mult_a_stb,
    output logic                 mult_b_stb,
    input  logic                 mult_a_ack,
    input  logic                 mult_b_ack,
    input  logic [W-1:0]         mult_z,
    input  logic                 mult_z_stb,
    output logic                 mult_z_ack,
    input  logic [$clog2(N)-1:0] rd_idx,
    output logic [W-1:0]         rd_data
);

    localparam int IW = $clog2(N);

    feed_state_t   state_r;
    logic [IW-1:0] idx_r;
    logic          busy_r, done_r, a_stb_r, b_stb_r, z_ack_r;
    logic [W-1:0]  mult_a_r, mult_b_r;

    logic [IW-1:0] rd_ptr_s;
    logic [W-1:0]  a_rd_s, b_rd_s, a_fwd_s, b_fwd_s;
    logic          wr_a_s, wr_b_s, wr_p_s, a_left_s, b_left_s;

    // Bank read pointer, write enables and same-cycle load forwarding at start.
    always_comb begin
        rd_ptr_s = '0;
        if (state_r == ST_NEXT) begin
            rd_ptr_s = idx_r + IW'(1);
        end else begin
            rd_ptr_s = '0;
        end
        wr_a_s   = (state_r == ST_IDLE) && load_we && !load_sel;
        wr_b_s   = (state_r == ST_IDLE) && load_we && load_sel;
        wr_p_s   = (state_r == ST_WAIT_Z) && mult_z_stb && z_ack_r;
        a_left_s = a_stb_r && !mult_a_ack;
        b_left_s = b_stb_r && !mult_b_ack;
        a_fwd_s  = a_rd_s;
        b_fwd_s  = b_rd_s;
        if (wr_a_s && (load_idx == '0)) begin
            a_fwd_s = load_data;
        end else begin
            a_fwd_s = a_rd_s;
        end
        if (wr_b_s && (load_idx == '0)) begin
            b_fwd_s = load_data;
        end else begin
            b_fwd_s = b_rd_s;
        end
    end

    feeder_regfile #(.N(N), .W(W)) u_bank_a (
        .clk(clk), .rst(rst), .we(wr_a_s), .waddr(load_idx), .wdata(load_data),
        .raddr(rd_ptr_s), .rdata(a_rd_s)
    );

    feeder_regfile #(.N(N), .W(W)) u_bank_b (
        .clk(clk), .rst(rst), .we(wr_b_s), .waddr(load_idx), .wdata(load_data),
        .raddr(rd_ptr_s), .rdata(b_rd_s)
    );

    feeder_regfile #(.N(N), .W(W)) u_bank_p (
        .clk(clk), .rst(rst), .we(wr_p_s), .waddr(idx_r), .wdata(mult_z),
        .raddr(rd_idx), .rdata(rd_data)
    );

    // Run sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            a_stb_r  <= 1'b0;
            b_stb_r  <= 1'b0;
            z_ack_r  <= 1'b0;
            mult_a_r <= '0;
            mult_b_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r  <= ST_SEND;
                        idx_r    <= '0;
                        busy_r   <= 1'b1;
                        a_stb_r  <= 1'b1;
                        b_stb_r  <= 1'b1;
                        mult_a_r <= a_fwd_s;
                        mult_b_r <= b_fwd_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    a_stb_r <= a_left_s;
                    b_stb_r <= b_left_s;
                    if (!a_left_s && !b_left_s) begin
                        state_r <= ST_WAIT_Z;
                        z_ack_r <= 1'b1;
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                ST_WAIT_Z: begin
                    if (mult_z_stb) begin
                        z_ack_r <= 1'b0;
                        state_r <= ST_NEXT;
                    end else begin
                        state_r <= ST_WAIT_Z;
                    end
                end
                ST_NEXT: begin
                    if (idx_r == IW'(N - 1)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r  <= ST_SEND;
                        idx_r    <= idx_r + IW'(1);
                        a_stb_r  <= 1'b1;
                        b_stb_r  <= 1'b1;
                        mult_a_r <= a_rd_s;
                        mult_b_r <= b_rd_s;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    a_stb_r <= 1'b0;
                    b_stb_r <= 1'b0;
                    z_ack_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign mult_a     = mult_a_r;
    assign mult_b     = mult_b_r;
    assign mult_a_stb = a_stb_r;
    assign mult_b_stb = b_stb_r;
    assign mult_z_ack = z_ack_r;

endmodule
